// File: rtl/dbus_arbiter.sv
// Two-master round-robin arbiter/sequencer for the MEM-stage data bus.
// Optional BUSY timeout abort is compiled in with `define DBUS_TIMEOUT_EN.
module dbus_arbiter #(
    parameter int TIMEOUT  = 255,
    parameter int RST_PRIO = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_m0_req,
    input  logic        i_m0_we,
    input  logic [31:0] i_m0_addr,
    input  logic [3:0]  i_m0_sel,
    input  logic [31:0] i_m0_wdata,
    output logic [31:0] o_m0_rdata,
    output logic        o_m0_rsp,
    output logic        o_m0_err,
    input  logic        i_m1_req,
    input  logic        i_m1_we,
    input  logic [31:0] i_m1_addr,
    input  logic [3:0]  i_m1_sel,
    input  logic [31:0] i_m1_wdata,
    output logic [31:0] o_m1_rdata,
    output logic        o_m1_rsp,
    output logic        o_m1_err,
    output logic        o_dbus_req,
    output logic        o_dbus_we,
    output logic [31:0] o_dbus_addr,
    output logic [3:0]  o_dbus_sel,
    output logic [31:0] o_dbus_wdata,
    input  logic [31:0] i_dbus_rdata,
    input  logic        i_dbus_rsp,
    output logic [1:0]  o_grant
);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    state_t      state_r;
    logic        prio_r;
    logic        win_s;
    logic        we_s;
    logic [31:0] addr_s;
    logic [3:0]  sel_s;
    logic [31:0] wdata_s;
    logic        timeout_s;
    logic        done_s;

`ifdef DBUS_TIMEOUT_EN
    localparam int CLOG_W = $clog2(TIMEOUT);
    localparam int CW     = (CLOG_W < 8) ? 8 : ((CLOG_W > 32) ? 32 : CLOG_W);

    logic [CW-1:0] cnt_r;

    assign timeout_s = (state_r == ST_BUSY) && !i_dbus_rsp && (cnt_r == CW'(TIMEOUT - 1));

    // Cycles spent in BUSY without a bus response
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_r <= '0;
        end else if (state_r != ST_BUSY || done_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end
`else
    logic timeout_unused_s;

    assign timeout_unused_s = (TIMEOUT < 2);
    assign timeout_s        = 1'b0;
`endif

    // Winner selection: a lone requester wins, a tie goes to the priority holder
    always_comb begin
        win_s = (i_m0_req && i_m1_req) ? prio_r : i_m1_req;
        if (win_s) begin
            we_s    = i_m1_we;
            addr_s  = i_m1_addr;
            sel_s   = i_m1_sel;
            wdata_s = i_m1_wdata;
        end else begin
            we_s    = i_m0_we;
            addr_s  = i_m0_addr;
            sel_s   = i_m0_sel;
            wdata_s = i_m0_wdata;
        end
    end

    assign done_s = (state_r == ST_BUSY) && (i_dbus_rsp || timeout_s);

    // Grant FSM and registered bus request
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            prio_r       <= (RST_PRIO != 0);
            o_grant      <= 2'b00;
            o_dbus_req   <= 1'b0;
            o_dbus_we    <= 1'b0;
            o_dbus_addr  <= 32'd0;
            o_dbus_sel   <= 4'd0;
            o_dbus_wdata <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_m0_req || i_m1_req) begin
                        state_r      <= ST_BUSY;
                        o_grant      <= win_s ? 2'b10 : 2'b01;
                        o_dbus_req   <= 1'b1;
                        o_dbus_we    <= we_s;
                        o_dbus_addr  <= addr_s;
                        o_dbus_sel   <= sel_s;
                        o_dbus_wdata <= we_s ? wdata_s : 32'd0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (done_s) begin
                        state_r      <= ST_IDLE;
                        prio_r       <= o_grant[0];
                        o_grant      <= 2'b00;
                        o_dbus_req   <= 1'b0;
                        o_dbus_we    <= 1'b0;
                        o_dbus_addr  <= 32'd0;
                        o_dbus_sel   <= 4'd0;
                        o_dbus_wdata <= 32'd0;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    o_grant      <= 2'b00;
                    o_dbus_req   <= 1'b0;
                    o_dbus_we    <= 1'b0;
                    o_dbus_addr  <= 32'd0;
                    o_dbus_sel   <= 4'd0;
                    o_dbus_wdata <= 32'd0;
                end
            endcase
        end
    end

    // Completion is same-cycle with the bus response, steered to the owner only
    assign o_m0_rsp   = done_s && o_grant[0];
    assign o_m1_rsp   = done_s && o_grant[1];
    assign o_m0_err   = timeout_s && o_grant[0];
    assign o_m1_err   = timeout_s && o_grant[1];
    assign o_m0_rdata = (o_m0_rsp && !o_dbus_we && !timeout_s) ? i_dbus_rdata : 32'd0;
    assign o_m1_rdata = (o_m1_rsp && !o_dbus_we && !timeout_s) ? i_dbus_rdata : 32'd0;

endmodule
